timer_irq_controller: RTL

- Memory-mapped timer and interrupt source for the single-cycle MIPS core.
- Sits on the data-memory bus beside data RAM.
- Drives the IRQ input of the instruction-decode control unit, which redirects the PC to the interrupt vector when not in kernel mode.
- Provides a reloadable up-counter with prescaler, a latched interrupt flag with write-1-to-clear, and a free-running cycle counter.

---
 rtl/timer_irq_pkg.sv | 15 +
 rtl/timer_prescaler.sv | 33 +++
 rtl/timer_irq_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/timer_irq_pkg.sv
// Shared constants for the timer / interrupt controller.
//   Register byte offsets inside the 32-byte window and TCON bit positions.
package timer_irq_pkg;

    localparam logic [4:0] OFF_TH     = 5'h00;
    localparam logic [4:0] OFF_TL     = 5'h04;
    localparam logic [4:0] OFF_TCON   = 5'h08;
    localparam logic [4:0] OFF_PSC    = 5'h0C;
    localparam logic [4:0] OFF_CYCLES = 5'h10;

    localparam int TEN_BIT = 0;
    localparam int TIE_BIT = 1;
    localparam int TIF_BIT = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler down-counter for the timer.
//   clk, reset : clock, async active-high reset
//   en         : count enable (TEN); when low the count is held at reload
//   load       : force count <= reload at the next edge
//   reload     : prescaler reload value
//   tick       : one-cycle pulse when the count reaches zero while enabled
module timer_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [PSC_W-1:0] reload,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - PSC_W'(1);
        // A tick period is reload+1 cycles: reload on the zero cycle itself.
        if (!en || load || tick) cnt_d = reload;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timer_irq_controller.sv
// Memory-mapped timer and interrupt source on the data-memory bus.
//   clk, reset : clock, async active-high reset
//   rd, wr     : bus read / write strobes
//   addr       : byte address (addr[1:0] ignored), window is 32 bytes at BASE_ADDR
//   wdata      : write data
//   rdata      : combinational read data, 0 when not reading a mapped register
//   irq        : TIE & TIF
//   tick       : prescaled timer tick pulse
module timer_irq_controller
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PSC_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick
);

    logic [31:0]      th_q, th_d, tl_q, tl_d, cyc_q, cyc_d;
    logic             ten_q, ten_d, tie_q, tie_d, tif_q, tif_d;
    logic [PSC_W-1:0] psc_q, psc_d, psc_reload;
    logic             hit, ovf, psc_load;
    logic             wr_th, wr_tl, wr_tcon, wr_psc;
    logic [4:0]       off;
    logic             unused_addr;

    assign unused_addr = ^addr[1:0];

    assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
    assign off     = {addr[4:2], 2'b00};
    assign wr_th   = wr && hit && (off == OFF_TH);
    assign wr_tl   = wr && hit && (off == OFF_TL);
    assign wr_tcon = wr && hit && (off == OFF_TCON);
    assign wr_psc  = wr && hit && (off == OFF_PSC);

    // Reload from the value being written so the new PSC takes effect at once.
    assign psc_reload = wr_psc ? wdata[PSC_W-1:0] : psc_q;
    assign psc_load   = wr_psc || (wr_tcon && wdata[TEN_BIT] && !ten_q);

    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk    (clk),
        .reset  (reset),
        .en     (ten_q),
        .load   (psc_load),
        .reload (psc_reload),
        .tick   (tick)
    );

    assign ovf = tick && (tl_q == 32'hFFFF_FFFF);
    assign irq = tie_q && tif_q;

    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        ten_d = ten_q;
        tie_d = tie_q;
        tif_d = tif_q;
        psc_d = psc_q;
        cyc_d = cyc_q + 32'd1;
        // Ordering below encodes the collision rules: CPU TL write beats the
        // tick, TL reloads from the old TH, and overflow set beats W1C.
        if (tick)    tl_d = ovf ? th_q : tl_q + 32'd1;
        if (wr_th)   th_d = wdata;
        if (wr_tl)   tl_d = wdata;
        if (wr_tcon) begin
            ten_d = wdata[TEN_BIT];
            tie_d = wdata[TIE_BIT];
            if (wdata[TIF_BIT]) tif_d = 1'b0;
        end
        if (ovf)     tif_d = 1'b1;
        if (wr_psc)  psc_d = wdata[PSC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q  <= '0;
            tl_q  <= '0;
            ten_q <= 1'b0;
            tie_q <= 1'b0;
            tif_q <= 1'b0;
            psc_q <= '0;
            cyc_q <= '0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            ten_q <= ten_d;
            tie_q <= tie_d;
            tif_q <= tif_d;
            psc_q <= psc_d;
            cyc_q <= cyc_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (off)
                OFF_TH:     rdata = th_q;
                OFF_TL:     rdata = tl_q;
                OFF_TCON:   rdata = {29'd0, tif_q, tie_q, ten_q};
                OFF_PSC:    rdata[PSC_W-1:0] = psc_q;
                OFF_CYCLES: rdata = cyc_q;
                default:    rdata = '0;
            endcase
        end
    end

endmodule
